// File: rtl/ped_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : ped_mon_pkg                                                |
// | Brief   : Shared types and constants for the pedestrian light        |
// |           monitor: phase enum, error codes, port bit positions.      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package ped_mon_pkg;

   // Car phase as seen on the lights; values double as the uo_out phase field
   typedef enum logic [1:0] {
      PH_UNKNOWN = 2'd0,
      PH_GREEN   = 2'd1,
      PH_YELLOW  = 2'd2,
      PH_RED     = 2'd3
   } phase_e;

   // Error codes; a lower number has higher priority when several coincide
   localparam logic [2:0] c_err_none = 3'd0;
   localparam logic [2:0] c_e1       = 3'd1;  // more than one car light lit
   localparam logic [2:0] c_e2       = 3'd2;  // dark for too long
   localparam logic [2:0] c_e3       = 3'd3;  // walk shown while cars not on red
   localparam logic [2:0] c_e4       = 3'd4;  // illegal phase transition
   localparam logic [2:0] c_e5       = 3'd5;  // walk and don't-walk both lit
   localparam logic [2:0] c_e6       = 3'd6;  // yellow too short
   localparam logic [2:0] c_e7       = 3'd7;  // pedestrian waited too long

   // ui_in bit positions
   localparam int unsigned c_ui_red        = 0;
   localparam int unsigned c_ui_yellow     = 1;
   localparam int unsigned c_ui_green      = 2;
   localparam int unsigned c_ui_walk       = 3;
   localparam int unsigned c_ui_dont_walk  = 4;
   localparam int unsigned c_ui_button     = 5;
   localparam int unsigned c_ui_clear      = 6;

   // uo_out bit positions (multi-bit fields give their LSB)
   localparam int unsigned c_uo_err_flag   = 0;
   localparam int unsigned c_uo_first_err  = 1;
   localparam int unsigned c_uo_phase      = 4;
   localparam int unsigned c_uo_dark       = 6;
   localparam int unsigned c_uo_ped_viol   = 7;

   // The only phase a lit phase may legally move to
   function automatic phase_e legal_successor(input phase_e p);
      phase_e nxt;
      case (p)
         PH_GREEN:  nxt = PH_YELLOW;
         PH_YELLOW: nxt = PH_RED;
         PH_RED:    nxt = PH_GREEN;
         default:   nxt = PH_UNKNOWN;
      endcase
      return nxt;
   endfunction

   // Number of car lights currently lit
   function automatic logic [1:0] lit_count(input logic [2:0] lights);
      return 2'(lights[0]) + 2'(lights[1]) + 2'(lights[2]);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ped_mon_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ped_mon_sync                                                |
// | Brief  : Two-flop input synchronizer with async active-low reset and |
// |          an enable that freezes both stages.                        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ped_mon_sync
   import ped_mon_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // Two-stage capture; both stages hold while the design is disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else if (ena) begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/tt_um_richardgonzalez_ped_light_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tt_um_richardgonzalez_ped_light_monitor                     |
// | Brief  : Watches car and pedestrian lights, tracks the car phase,   |
// |          flags illegal behaviour with a sticky first-error code and  |
// |          counts completed car cycles.                               |
// | Option : PED_WAIT_CHECK_EN builds the pedestrian wait-time checker.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tt_um_richardgonzalez_ped_light_monitor
   import ped_mon_pkg::*;
#(
   parameter int unsigned MIN_YELLOW   = 4,
   parameter int unsigned MAX_DARK     = 2,
   parameter int unsigned MAX_PED_WAIT = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [7:0]  w_sync;
   logic        w_red, w_yellow, w_green;
   logic        w_walk, w_dont_walk, w_clear;

   phase_e      r_phase, w_phase_next, w_target;
   logic [15:0] r_dur, w_dur_next;
   logic [15:0] r_dark_cnt, w_dark_next;
   logic [7:0]  r_cycle_cnt, w_cycle_next;
   logic        r_err_flag, w_err_flag_next;
   logic [2:0]  r_first_err, w_first_err_next;

   logic        w_e1, w_e2, w_e3, w_e4, w_e5, w_e6, w_e7;
   logic [2:0]  w_err_code;
   logic        w_err_new;
   logic        w_ped_viol;
   logic        w_unused;

   ped_mon_sync #(
      .WIDTH (8)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .d     (ui_in),
      .q     (w_sync)
   );

   assign w_red       = w_sync[c_ui_red];
   assign w_yellow    = w_sync[c_ui_yellow];
   assign w_green     = w_sync[c_ui_green];
   assign w_walk      = w_sync[c_ui_walk];
   assign w_dont_walk = w_sync[c_ui_dont_walk];
   assign w_clear     = w_sync[c_ui_clear];

   // Phase FSM next state, phase-duration / dark / cycle counters and E1..E6 detection
   always_comb begin
      w_phase_next = r_phase;
      w_target     = PH_UNKNOWN;
      w_dur_next   = (r_dur == 16'hFFFF) ? r_dur : r_dur + 16'd1;
      w_dark_next  = 16'd0;
      w_cycle_next = r_cycle_cnt;
      w_e1         = 1'b0;
      w_e2         = 1'b0;
      w_e4         = 1'b0;
      w_e6         = 1'b0;

      if (w_green) begin
         w_target = PH_GREEN;
      end else if (w_yellow) begin
         w_target = PH_YELLOW;
      end else if (w_red) begin
         w_target = PH_RED;
      end

      case (lit_count({w_green, w_yellow, w_red}))
         2'd0: begin
            w_dark_next = (r_dark_cnt == 16'hFFFF) ? r_dark_cnt : r_dark_cnt + 16'd1;
            w_e2        = (32'(w_dark_next) > MAX_DARK);
         end
         2'd1: begin
            if (w_target != r_phase) begin
               w_phase_next = w_target;
               w_dur_next   = 16'd0;
               // Coming out of UNKNOWN any lit phase is acceptable
               w_e4 = (r_phase != PH_UNKNOWN) && (w_target != legal_successor(r_phase));
               // r_dur counts clocks since entry, so an N-clock yellow leaves with N-1
               w_e6 = (r_phase == PH_YELLOW) && (32'(r_dur) < MIN_YELLOW);
               if ((r_phase == PH_RED) && (w_target == PH_GREEN)) begin
                  w_cycle_next = r_cycle_cnt + 8'd1;
               end
            end
         end
         default: begin
            w_e1 = 1'b1;
         end
      endcase
   end

   // Walk is judged against the phase being adopted this cycle, so red and walk
   // appearing together is not a violation
   assign w_e3 = w_walk & (w_phase_next != PH_RED);
   assign w_e5 = w_walk & w_dont_walk;

`ifdef PED_WAIT_CHECK_EN
   logic        r_btn_prev;
   logic        r_armed, w_armed_next;
   logic [15:0] r_wait_cnt, w_wait_next;
   logic        r_ped_viol, w_ped_viol_next;

   // Wait counter: armed by a button rising edge, disarmed as soon as walk shows
   always_comb begin
      w_armed_next = r_armed;
      w_wait_next  = r_wait_cnt;
      w_e7         = 1'b0;
      if (w_walk) begin
         w_armed_next = 1'b0;
      end else if (r_armed) begin
         w_wait_next = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;
         w_e7        = (32'(w_wait_next) > MAX_PED_WAIT);
      end else if (w_sync[c_ui_button] && !r_btn_prev) begin
         w_armed_next = 1'b1;
         w_wait_next  = 16'd0;
      end
      w_ped_viol_next = w_e7 | (r_ped_viol & ~w_clear);
   end

   // Wait-checker state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_prev <= 1'b0;
         r_armed    <= 1'b0;
         r_wait_cnt <= 16'd0;
         r_ped_viol <= 1'b0;
      end else if (ena) begin
         r_btn_prev <= w_sync[c_ui_button];
         r_armed    <= w_armed_next;
         r_wait_cnt <= w_wait_next;
         r_ped_viol <= w_ped_viol_next;
      end
   end

   assign w_ped_viol = r_ped_viol;
   assign w_unused   = ^{uio_in, w_sync[7]};
`else
   assign w_e7       = 1'b0;
   assign w_ped_viol = 1'b0;
   assign w_unused   = ^{uio_in, w_sync[7], w_sync[c_ui_button], 32'(MAX_PED_WAIT)};
`endif

   // Lowest code wins; a new error overrides a same-cycle clear
   always_comb begin
      if (w_e1) begin
         w_err_code = c_e1;
      end else if (w_e2) begin
         w_err_code = c_e2;
      end else if (w_e3) begin
         w_err_code = c_e3;
      end else if (w_e4) begin
         w_err_code = c_e4;
      end else if (w_e5) begin
         w_err_code = c_e5;
      end else if (w_e6) begin
         w_err_code = c_e6;
      end else if (w_e7) begin
         w_err_code = c_e7;
      end else begin
         w_err_code = c_err_none;
      end

      w_err_new       = (w_err_code != c_err_none);
      w_err_flag_next = w_err_new | (r_err_flag & ~w_clear);
      if (w_err_new && (!r_err_flag || w_clear)) begin
         w_first_err_next = w_err_code;
      end else if (w_clear) begin
         w_first_err_next = c_err_none;
      end else begin
         w_first_err_next = r_first_err;
      end
   end

   // Monitor state register; everything freezes while ena is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase     <= PH_UNKNOWN;
         r_dur       <= 16'd0;
         r_dark_cnt  <= 16'd0;
         r_cycle_cnt <= 8'd0;
         r_err_flag  <= 1'b0;
         r_first_err <= c_err_none;
      end else if (ena) begin
         r_phase     <= w_phase_next;
         r_dur       <= w_dur_next;
         r_dark_cnt  <= w_dark_next;
         r_cycle_cnt <= w_cycle_next;
         r_err_flag  <= w_err_flag_next;
         r_first_err <= w_first_err_next;
      end
   end

   // Output packing; all sources are registers, so reset drives zeros
   always_comb begin
      uo_out                        = 8'h00;
      uo_out[c_uo_err_flag]         = r_err_flag;
      uo_out[c_uo_first_err +: 3]   = r_first_err;
      uo_out[c_uo_phase +: 2]       = r_phase;
      uo_out[c_uo_dark]             = (r_dark_cnt != 16'd0);
      uo_out[c_uo_ped_viol]         = w_ped_viol;
   end

   assign uio_out = r_cycle_cnt;
   assign uio_oe  = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_richardgonzalez_ped_light_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_tt_um_richardgonzalez_ped_light_monitor                  |
// | Brief  : Directed plus randomized bench with a behavioural model of |
// |          the monitor rules. PED_WAIT_CHECK_EN selects the wait check.|
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_tt_um_richardgonzalez_ped_light_monitor;

   localparam int unsigned MIN_YELLOW   = 4;
   localparam int unsigned MAX_DARK     = 2;
   localparam int unsigned MAX_PED_WAIT = 20;

   localparam logic [7:0] RED   = 8'h01;
   localparam logic [7:0] YEL   = 8'h02;
   localparam logic [7:0] GRN   = 8'h04;
   localparam logic [7:0] WALK  = 8'h08;
   localparam logic [7:0] DONTW = 8'h10;
   localparam logic [7:0] BTN   = 8'h20;
   localparam logic [7:0] CLR   = 8'h40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: two-deep input delay line plus the rule state
   logic [7:0] m_s1, m_s2;
   int m_phase, m_dur, m_dark, m_first, m_cycles, m_wait;
   bit m_err, m_viol, m_btn_prev, m_armed;

   tt_um_richardgonzalez_ped_light_monitor #(
      .MIN_YELLOW   (MIN_YELLOW),
      .MAX_DARK     (MAX_DARK),
      .MAX_PED_WAIT (MAX_PED_WAIT)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   function automatic int lowest(input int cur, input int cand);
      return (cur == 0 || cand < cur) ? cand : cur;
   endfunction

   function automatic void model_reset();
      m_s1 = 8'h00; m_s2 = 8'h00;
      m_phase = 0; m_dur = 0; m_dark = 0; m_first = 0; m_cycles = 0; m_wait = 0;
      m_err = 1'b0; m_viol = 1'b0; m_btn_prev = 1'b0; m_armed = 1'b0;
   endfunction

   // One rising edge of the monitor, applied to what the delay line delivers.
   // Phases: 0 unknown, 1 green, 2 yellow, 3 red; successor of p is p%3+1.
   function automatic void model_clock(input logic [7:0] ui);
      logic [7:0] s;
      int lit, target, new_phase, code;
      bit walk, clr, e7;
      if (!ena) return;
      s = m_s2;
      lit = int'(s[0]) + int'(s[1]) + int'(s[2]);
      walk = s[3];
      clr = s[6];
      code = 0;
      e7 = 1'b0;
      new_phase = m_phase;

      if (lit == 1) begin
         target = s[0] ? 3 : (s[1] ? 2 : 1);
         if (target != m_phase) begin
            if (m_phase != 0 && target != (m_phase % 3) + 1) code = lowest(code, 4);
            if (m_phase == 2 && m_dur < int'(MIN_YELLOW)) code = lowest(code, 6);
            if (m_phase == 3 && target == 1) m_cycles = (m_cycles + 1) % 256;
            new_phase = target;
            m_dur = 0;
         end else begin
            m_dur = sat_inc(m_dur);
         end
      end else begin
         m_dur = sat_inc(m_dur);
      end

      if (lit > 1) code = lowest(code, 1);
      if (lit == 0) begin
         m_dark = sat_inc(m_dark);
         if (m_dark > int'(MAX_DARK)) code = lowest(code, 2);
      end else begin
         m_dark = 0;
      end

      if (walk && new_phase != 3) code = lowest(code, 3);
      if (walk && s[4]) code = lowest(code, 5);

`ifdef PED_WAIT_CHECK_EN
      if (walk) begin
         m_armed = 1'b0;
      end else if (m_armed) begin
         m_wait = sat_inc(m_wait);
         if (m_wait > int'(MAX_PED_WAIT)) begin
            e7 = 1'b1;
            code = lowest(code, 7);
         end
      end else if (s[5] && !m_btn_prev) begin
         m_armed = 1'b1;
         m_wait = 0;
      end
      m_btn_prev = s[5];
`endif

      if (code != 0 && (!m_err || clr)) m_first = code;
      else if (clr) m_first = 0;
      m_err = (code != 0) || (m_err && !clr);
      m_viol = e7 || (m_viol && !clr);
      m_phase = new_phase;

      m_s2 = m_s1;
      m_s1 = ui;
   endfunction

   function automatic logic [7:0] exp_uo();
      logic [7:0] v;
      v = 8'h00;
      v[0]   = m_err;
      v[3:1] = m_first[2:0];
      v[5:4] = m_phase[1:0];
      v[6]   = (m_dark != 0);
      v[7]   = m_viol;
      return v;
   endfunction

   // Drive one clock of stimulus and compare against the model after the edge
   task automatic tick(input logic [7:0] ui, input logic en = 1'b1);
      ui_in = ui;
      ena = en;
      @(posedge clk);
      model_clock(ui);
      #1;
      check("uo_out", {24'd0, uo_out}, {24'd0, exp_uo()});
      check("uio_out", {24'd0, uio_out}, 32'(m_cycles));
   endtask

   task automatic hold(input logic [7:0] ui, input int n);
      for (int i = 0; i < n; i++) tick(ui);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_uo_out", {24'd0, uo_out}, 32'h00);
      check("rst_uio_out", {24'd0, uio_out}, 32'h00);
      check("rst_uio_oe", {24'd0, uio_oe}, 32'hFF);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [7:0] light_bits(input int l);
      return (l == 0) ? GRN : ((l == 1) ? YEL : RED);
   endfunction

   task automatic random_run(input int n_seg);
      int light, len, kind;
      logic [7:0] ui;
      light = 0;
      for (int seg = 0; seg < n_seg; seg++) begin
         kind = int'($urandom_range(0, 11));
         len = int'($urandom_range(1, 8));
         if (kind <= 6) begin
            if ($urandom_range(0, 3) != 0) light = (light + 1) % 3;
            else light = int'($urandom_range(0, 2));
            ui = light_bits(light);
            if (light == 2 && $urandom_range(0, 1) == 1) ui = ui | WALK;
            else ui = ui | DONTW;
            if ($urandom_range(0, 7) == 0) ui = ui | BTN;
            hold(ui, len);
         end else if (kind == 7) begin
            for (int i = 0; i < (len % 3) + 1; i++) tick(8'($urandom));
         end else if (kind == 8) begin
            hold(8'h00, (len % 4) + 1);
         end else if (kind == 9) begin
            tick(light_bits(light) | CLR);
         end else if (kind == 10) begin
            for (int i = 0; i < (len % 5) + 1; i++) tick(8'($urandom), 1'b0);
         end else begin
            hold(light_bits(light) | WALK | ($urandom_range(0, 1) == 1 ? DONTW : 8'h00), (len % 3) + 1);
         end
      end
   endtask

   initial begin
      model_reset();
      apply_reset();

      // Legal G(10) -> Y(5) -> R(10) -> G cycle
      hold(GRN | DONTW, 10);
      check("seq_phase_g", {30'd0, uo_out[5:4]}, 32'd1);
      hold(YEL | DONTW, 5);
      hold(RED | WALK, 10);
      check("seq_phase_r", {30'd0, uo_out[5:4]}, 32'd3);
      hold(GRN | DONTW, 4);
      check("seq_no_err", {31'd0, uo_out[0]}, 32'd0);
      check("seq_cycles", {24'd0, uio_out}, 32'd1);
      check("seq_phase_g2", {30'd0, uo_out[5:4]}, 32'd1);

      // Green straight to red: E4 on the third edge after the change
      apply_reset();
      hold(GRN, 5);
      tick(RED);
      tick(RED);
      check("g2r_before", {31'd0, uo_out[0]}, 32'd0);
      tick(RED);
      check("g2r_flag", {31'd0, uo_out[0]}, 32'd1);
      check("g2r_code", {29'd0, uo_out[3:1]}, 32'd4);
      check("g2r_phase", {30'd0, uo_out[5:4]}, 32'd3);

      // Walk in green together with two car lights: E1 beats E3
      apply_reset();
      hold(GRN, 5);
      hold(RED | GRN | WALK, 4);
      check("e1_over_e3", {29'd0, uo_out[3:1]}, 32'd1);

      // Dark for 3 clocks, short yellow, then clear and clear-with-new-error
      apply_reset();
      hold(GRN, 5);
      hold(8'h00, 3);
      hold(GRN, 2);
      check("dark_code", {29'd0, uo_out[3:1]}, 32'd2);
      hold(YEL, 2);
      hold(RED, 4);
      check("short_yel_keeps", {29'd0, uo_out[3:1]}, 32'd2);
      tick(RED | CLR);
      hold(RED, 3);
      check("clear_flag", {31'd0, uo_out[0]}, 32'd0);
      check("clear_code", {29'd0, uo_out[3:1]}, 32'd0);
      tick(RED | GRN | CLR);
      hold(RED, 3);
      check("clr_new_flag", {31'd0, uo_out[0]}, 32'd1);
      check("clr_new_code", {29'd0, uo_out[3:1]}, 32'd1);

      // Pedestrian button pressed, walk never shown
      apply_reset();
      hold(RED | DONTW, 5);
      tick(RED | DONTW | BTN);
      hold(RED | DONTW, 30);
`ifdef PED_WAIT_CHECK_EN
      check("ped_viol", {31'd0, uo_out[7]}, 32'd1);
      check("ped_code", {29'd0, uo_out[3:1]}, 32'd7);
`else
      check("ped_viol_off", {31'd0, uo_out[7]}, 32'd0);
      check("ped_no_err", {31'd0, uo_out[0]}, 32'd0);
`endif

      // Randomized traffic, with clears, dark spells and ena gaps
      apply_reset();
      random_run(400);

      // 256 legal car cycles wrap the counter
      apply_reset();
      for (int c = 0; c < 256; c++) begin
         hold(GRN, 2);
         hold(YEL, 5);
         hold(RED, 2);
      end
      hold(RED, 2);
      check("wrap_255", {24'd0, uio_out}, 32'd255);
      hold(GRN, 4);
      check("wrap_0", {24'd0, uio_out}, 32'd0);
      check("wrap_no_err", {31'd0, uo_out[0]}, 32'd0);

      // Reset in the middle of yellow discards history
      hold(YEL, 3);
      apply_reset();
      hold(YEL, 6);
      check("post_rst_phase", {30'd0, uo_out[5:4]}, 32'd2);
      check("post_rst_err", {31'd0, uo_out[0]}, 32'd0);
      check("post_rst_cycles", {24'd0, uio_out}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tt_um_richardgonzalez_ped_light_monitor.md
TT_UM_RICHARDGONZALEZ_PED_LIGHT_MONITOR -- requirements
Module: tt_um_richardgonzalez_ped_light_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 4: minimum legal car-yellow duration, in clocks.
REQ-002 Parameter MAX_DARK, default 2: maximum consecutive clocks with no car light lit.
REQ-003 Parameter MAX_PED_WAIT, default 1000: maximum clocks from pedestrian button press to walk.
REQ-004 clk  input  1  single design clock; all state on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ena  input  1  design enable; low holds all state.
REQ-007 ui_in  input  8  observed bits: [0] car_red, [1] car_yellow, [2] car_green, [3] ped_walk, [4] ped_dont_walk, [5] ped_button, [6] clear_err; [7] unused.
REQ-008 uo_out  output  8  [0] err_flag, [3:1] first_err code, [5:4] phase (0 UNKNOWN, 1 GREEN, 2 YELLOW, 3 RED), [6] dark_active, [7] ped_wait_viol.
REQ-009 uio_in  input  8  unused.
REQ-010 uio_out  output  8  completed car-cycle count.
REQ-011 uio_oe  output  8  constant 8'hFF.

Function
REQ-012 All ui_in bits pass through a 2-flop synchronizer; decoded responses appear on outputs at the 3rd rising edge after an input change.
REQ-013 Phase FSM: UNKNOWN, GREEN, YELLOW, RED; exactly one car light lit selects the target phase.
REQ-014 Legal transitions are GREEN->YELLOW, YELLOW->RED, RED->GREEN, and UNKNOWN->any; these raise no error.
REQ-015 Illegal transitions (GREEN->RED, YELLOW->GREEN, RED->YELLOW) raise E4; the FSM still adopts the new phase.
REQ-016 More than one car light lit raises E1; phase is unchanged.
REQ-017 No car light lit: the dark counter increments and dark_active=1; count > MAX_DARK raises E2; phase is unchanged; the counter clears when any light is lit.
REQ-018 ped_walk=1 while phase != RED raises E3.
REQ-019 ped_walk and ped_dont_walk both 1 raises E5.
REQ-020 A 16-bit phase-duration counter resets to 0 on every phase change and saturates at 16'hFFFF.
REQ-021 Leaving YELLOW with duration < MIN_YELLOW raises E6.
REQ-022 Error codes: E1=1, E2=2, E3=3, E4=4, E5=5, E6=6, E7=7 (ped wait); code 0 means no error.
REQ-023 Same-cycle errors: the lowest code wins.
REQ-024 err_flag is sticky; first_err latches only while err_flag=0.
REQ-025 clear_err=1 zeroes err_flag and first_err; a new error in the same cycle wins and sets both.
REQ-026 The cycle count increments on each RED->GREEN transition and wraps 255->0; clear_err does not affect it.
REQ-027 ena=0: all registers hold, including synchronizers; outputs hold.

Reset
REQ-028 rst_n=0 asynchronously sets: phase=UNKNOWN; all counters=0; err_flag=0; first_err=0; ped_wait_viol=0; synchronizers=0.
REQ-029 uo_out=8'h00, uio_out=8'h00, uio_oe=8'hFF while in reset.
REQ-030 Reset asserted mid-phase discards all history; after release, the first lit phase is treated as coming from UNKNOWN.

Configuration
REQ-031 Macro PED_WAIT_CHECK_EN, when defined: a rising ped_button arms a wait counter; ped_walk=1 disarms it.
REQ-032 Under PED_WAIT_CHECK_EN, armed count > MAX_PED_WAIT sets sticky ped_wait_viol and raises E7; clear_err clears ped_wait_viol.
REQ-033 PED_WAIT_CHECK_EN undefined: no wait counter is built, uo_out[7]=0, and E7 never occurs.

Structure
REQ-034 Package ped_mon_pkg holds the phase enum, error-code constants E1..E7, and the uo_out bit-position constants.
REQ-035 Sub-module ped_mon_sync implements the 8-bit 2-flop synchronizer with async active-low reset and ena hold.

Verification
REQ-036 Sequence GREEN(10)->YELLOW(5)->RED(10)->GREEN -> no error; uio_out=1; phase reads 1, 2, 3, 1.
REQ-037 GREEN directly to RED -> err_flag=1, first_err=4 at the 3rd edge after the change; phase=3.
REQ-038 ped_walk=1 during GREEN, together with red+green lit -> first_err=1 (E1 beats E3).
REQ-039 All lights off for 3 clocks with MAX_DARK=2 -> first_err=2; then YELLOW held 2 clocks -> first_err stays 2; clear_err and a new error in the same cycle -> err_flag=1 with the new code.
REQ-040 With PED_WAIT_CHECK_EN and MAX_PED_WAIT=20: button press, no walk for 25 clocks -> uo_out[7]=1, first_err=7; without the macro -> uo_out[7]=0.
REQ-041 256 legal car cycles -> uio_out wraps to 0; rst_n pulsed mid-YELLOW -> all outputs 0, phase UNKNOWN.
